// File: rtl/cntry_vehicle_detector.sv
// Country-road vehicle detector.
// Synchronises and debounces the raw loop input, keeps a count of queued
// country vehicles, retires them while the country light is GREEN, and
// raises the `sensor` request for sig_control while traffic is waiting or
// being served. A max-green limit forces the request off so the main road
// cannot be starved.
module cntry_vehicle_detector #(
  parameter int DEBOUNCE  = 4,
  parameter int DEPART    = 8,
  parameter int MAX_GREEN = 64,
  parameter int CW        = 4,
  parameter int TW        = 8
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          raw_loop,
  input  logic [1:0]    cntry,
  output logic          sensor,
  output logic [CW-1:0] queue_cnt,
  output logic          overflow
);

  localparam logic [1:0]    LIGHT_RED   = 2'd0;
  localparam logic [1:0]    LIGHT_GREEN = 2'd2;
  localparam logic [CW-1:0] QMAX        = '1;
  localparam logic [TW-1:0] DB_LAST     = TW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] DEP_LAST    = TW'(DEPART - 1);
  localparam logic [TW-1:0] GRN_LAST    = TW'(MAX_GREEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    SERVE     = 2'd2,
    FORCE_OFF = 2'd3
  } state_t;

  state_t        state;
  logic          sync_p0;
  logic          sync_p1;
  logic          db;
  logic          db_q;
  logic [TW-1:0] db_cnt;
  logic [TW-1:0] dep_tmr;
  logic [TW-1:0] grn_tmr;
  logic          arrive;
  logic          depart;
  logic          green;
  logic [CW-1:0] cnt_nxt;

  // Queue count after one cycle: an arrival and a departure together cancel,
  // a lone arrival saturates at QMAX, a lone departure floors at zero.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic          arr,
                                               input logic          dep);
    logic [CW-1:0] res;
    res = cnt;
    if (arr && !dep) begin
      if (cnt != QMAX) res = cnt + 1'b1;
    end else if (dep && !arr) begin
      if (cnt != '0) res = cnt - 1'b1;
    end
    return res;
  endfunction

  // An arrival is lost only when it cannot take the slot of a departure.
  function automatic logic arrival_dropped(input logic [CW-1:0] cnt,
                                           input logic          arr,
                                           input logic          dep);
    return arr && !dep && (cnt == QMAX);
  endfunction

  assign arrive  = db & ~db_q;
  assign depart  = (state == SERVE) && (dep_tmr == DEP_LAST);
  assign green   = (cntry == LIGHT_GREEN);
  assign cnt_nxt = next_count(queue_cnt, arrive, depart);
  assign sensor  = (state == REQ) || (state == SERVE);

  // Stage p0/p1: two-flop synchroniser for the asynchronous loop input
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_loop;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level must differ from db for DEBOUNCE consecutive edges
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      db_q <= db;
      if (sync_p1 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Queue counter and sticky overflow flag
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      queue_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      queue_cnt <= cnt_nxt;
      if (arrival_dropped(queue_cnt, arrive, depart)) overflow <= 1'b1;
    end
  end

  // Departure and green timers run in SERVE and sit at zero otherwise,
  // so every SERVE visit starts from a cleared timer
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      dep_tmr <= '0;
      grn_tmr <= '0;
    end else if (state == SERVE) begin
      dep_tmr <= depart ? '0 : dep_tmr + 1'b1;
      grn_tmr <= grn_tmr + 1'b1;
    end else begin
      dep_tmr <= '0;
      grn_tmr <= '0;
    end
  end

  // Request state machine
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arrive) state <= REQ;
        end
        REQ: begin
          if (green) state <= SERVE;
        end
        SERVE: begin
          if (!green)                    state <= (cnt_nxt != '0) ? REQ : IDLE;
          else if (grn_tmr == GRN_LAST)  state <= FORCE_OFF;
          else if (cnt_nxt == '0)        state <= IDLE;
        end
        FORCE_OFF: begin
          if (cntry == LIGHT_RED) state <= (queue_cnt != '0) ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Testbench for cntry_vehicle_detector: directed scenarios followed by
// randomized loop/light traffic, every cycle compared against a behavioural
// model of the queue and request rules.
module tb_cntry_vehicle_detector;

  localparam int DEBOUNCE  = 4;
  localparam int DEPART    = 8;
  localparam int MAX_GREEN = 64;
  localparam int CW        = 4;
  localparam int TW        = 8;
  localparam int QMAX      = (1 << CW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_REQ   = 1;
  localparam int PH_SERVE = 2;
  localparam int PH_FORCE = 3;

  logic          clock = 1'b0;
  logic          clear_n;
  logic          raw_loop;
  logic [1:0]    cntry;
  logic          sensor;
  logic [CW-1:0] queue_cnt;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_db, m_dbq, m_cnt, m_ovf, m_ph, m_sc;
  bit raw_hist[$];
  bit s2_hist[$];

  cntry_vehicle_detector #(
    .DEBOUNCE (DEBOUNCE),
    .DEPART   (DEPART),
    .MAX_GREEN(MAX_GREEN),
    .CW       (CW),
    .TW       (TW)
  ) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .raw_loop (raw_loop),
    .cntry    (cntry),
    .sensor   (sensor),
    .queue_cnt(queue_cnt),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_db = 0; m_dbq = 0; m_cnt = 0; m_ovf = 0; m_ph = PH_IDLE; m_sc = 0;
    raw_hist.delete();
    s2_hist.delete();
  endtask

  function automatic int model_sensor();
    return (m_ph == PH_REQ || m_ph == PH_SERVE) ? 1 : 0;
  endfunction

  // One clock edge of the detector, from the rules in plain arithmetic
  task automatic model_edge();
    int  arrive, depart, ncnt, nph, s2, all_diff;
    bit  is_green;
    arrive   = (m_db == 1 && m_dbq == 0) ? 1 : 0;
    depart   = (m_ph == PH_SERVE && (m_sc % DEPART) == DEPART - 1) ? 1 : 0;
    ncnt     = m_cnt;
    if (arrive && !depart) begin
      if (m_cnt == QMAX) m_ovf = 1;
      else ncnt = m_cnt + 1;
    end else if (depart && !arrive && m_cnt > 0) begin
      ncnt = m_cnt - 1;
    end
    is_green = (cntry == 2'd2);
    nph = m_ph;
    case (m_ph)
      PH_IDLE:  if (arrive) nph = PH_REQ;
      PH_REQ:   if (is_green) begin nph = PH_SERVE; m_sc = 0; end
      PH_SERVE: begin
        if (!is_green)                nph = (ncnt > 0) ? PH_REQ : PH_IDLE;
        else if (m_sc == MAX_GREEN-1) nph = PH_FORCE;
        else if (ncnt == 0)           nph = PH_IDLE;
        else                          m_sc = m_sc + 1;
      end
      default:  if (cntry == 2'd0) nph = (m_cnt > 0) ? PH_REQ : PH_IDLE;
    endcase
    m_cnt = ncnt;
    m_ph  = nph;
    // synchronised level seen this edge is the raw sample from two edges ago
    s2 = (raw_hist.size() == 2) ? int'(raw_hist[0]) : 0;
    raw_hist.push_back(raw_loop);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    s2_hist.push_back(bit'(s2));
    if (s2_hist.size() > DEBOUNCE) void'(s2_hist.pop_front());
    all_diff = (s2_hist.size() == DEBOUNCE) ? 1 : 0;
    foreach (s2_hist[i]) if (int'(s2_hist[i]) == m_db) all_diff = 0;
    m_dbq = m_db;
    if (all_diff) m_db = 1 - m_db;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_val("sensor",    32'(sensor),    32'(model_sensor()));
    check_val("queue_cnt", 32'(queue_cnt), 32'(m_cnt));
    check_val("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted between clock edges; outputs must clear at once
  task automatic async_reset();
    @(posedge clock);
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_sensor",   32'(sensor),    32'd0);
    check_val("rst_queue",    32'(queue_cnt), 32'd0);
    check_val("rst_overflow", 32'(overflow),  32'd0);
    @(posedge clock);
    #3 clear_n = 1'b1;
  endtask

  task automatic one_arrival();
    raw_loop = 1'b1;
    steps(6);
    raw_loop = 1'b0;
    steps(8);
  endtask

  initial begin
    int cntry_left, raw_left, r;
    clear_n  = 1'b0;
    raw_loop = 1'b0;
    cntry    = 2'd0;
    model_reset();
    #1;
    check_val("init_sensor",   32'(sensor),    32'd0);
    check_val("init_queue",    32'(queue_cnt), 32'd0);
    check_val("init_overflow", 32'(overflow),  32'd0);
    repeat (2) @(posedge clock);
    #3 clear_n = 1'b1;

    // glitch shorter than the debounce window
    raw_loop = 1'b1;
    steps(3);
    raw_loop = 1'b0;
    steps(10);
    check_val("glitch_queue",  32'(queue_cnt), 32'd0);
    check_val("glitch_sensor", 32'(sensor),    32'd0);

    // clean arrival: counted at edge 3+DEBOUNCE
    raw_loop = 1'b1;
    steps(6);
    check_val("arr_q_edge6", 32'(queue_cnt), 32'd0);
    steps(1);
    check_val("arr_q_edge7", 32'(queue_cnt), 32'd1);
    check_val("arr_s_edge7", 32'(sensor),    32'd1);
    steps(3);
    raw_loop = 1'b0;
    cntry    = 2'd2;
    steps(8);
    check_val("serve_s_c7", 32'(sensor),    32'd1);
    steps(1);
    check_val("serve_s_c8", 32'(sensor),    32'd0);
    check_val("serve_q_c8", 32'(queue_cnt), 32'd0);

    // fill the queue past QMAX under RED
    cntry = 2'd0;
    for (int i = 0; i < 16; i++) one_arrival();
    check_val("full_queue",    32'(queue_cnt), 32'd15);
    check_val("full_overflow", 32'(overflow),  32'd1);
    check_val("full_sensor",   32'(sensor),    32'd1);
    one_arrival();
    check_val("full_queue2",   32'(queue_cnt), 32'd15);

    // max-green timeout with a coincident departure
    cntry = 2'd2;
    steps(64);
    check_val("tmo_s_c63", 32'(sensor),    32'd1);
    check_val("tmo_q_c63", 32'(queue_cnt), 32'd8);
    steps(1);
    check_val("tmo_s_c64", 32'(sensor),    32'd0);
    check_val("tmo_q_c64", 32'(queue_cnt), 32'd7);
    cntry = 2'd1;
    steps(3);
    check_val("force_yel", 32'(sensor), 32'd0);
    cntry = 2'd0;
    steps(1);
    check_val("force_red", 32'(sensor), 32'd1);

    // reset in the middle of SERVE
    cntry = 2'd2;
    steps(3);
    async_reset();
    steps(2);

    // randomized traffic
    cntry_left = 0;
    raw_left   = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cntry_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)       cntry = 2'd0;
        else if (r < 8)  cntry = 2'd2;
        else if (r == 8) cntry = 2'd1;
        else             cntry = 2'd3;
        cntry_left = $urandom_range(1, 90);
      end
      if (raw_left == 0) begin
        raw_loop = ~raw_loop;
        raw_left = $urandom_range(1, 12);
      end
      cntry_left--;
      raw_left--;
      if ($urandom_range(0, 999) == 0) async_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
